// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arbiter : round-robin sharing of one combinational ALU between
// the execute stage (req 0) and the debug/loader port (req 1).
// Optional macro ALU_ARB_STATS_EN adds per-requester grant counters. Rev 1.0
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [CTRL_W-1:0]   req0_ctrl,
  input  logic [4*DATA_W-1:0] req0_opnd,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [CTRL_W-1:0]   req1_ctrl,
  input  logic [4*DATA_W-1:0] req1_opnd,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [DATA_W-1:0]   rsp0_result,
  output logic                rsp0_zero,
  output logic                rsp0_branch,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [DATA_W-1:0]   rsp1_result,
  output logic                rsp1_zero,
  output logic                rsp1_branch,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0]   alu_rd1,
  output logic [DATA_W-1:0]   alu_rd2,
  output logic [DATA_W-1:0]   alu_pc,
  output logic [DATA_W-1:0]   alu_imm,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  input  logic                alu_branch,
`ifdef ALU_ARB_STATS_EN
  input  logic                stats_clr,
  output logic [31:0]         grant_cnt0,
  output logic [31:0]         grant_cnt1,
`endif
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state_q, state_d;
  logic                     last_q, last_d;
  logic                     winner_q, winner_d;
  logic [CTRL_W-1:0]        alu_ctrl_q, alu_ctrl_d;
  logic [4*DATA_W-1:0]      alu_opnd_q, alu_opnd_d;
  logic [1:0]               rsp_valid_q, rsp_valid_d;
  logic [1:0]               rsp_zero_q, rsp_zero_d;
  logic [1:0]               rsp_branch_q, rsp_branch_d;
  logic [1:0][DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                     grant0, grant1, rsp_taken;

  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
  assign grant0    = rst_n && (state_q == IDLE) && req0_valid && (!req1_valid || last_q);
  assign grant1    = rst_n && (state_q == IDLE) && req1_valid && (!req0_valid || !last_q);
  assign rsp_taken = winner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    winner_d     = winner_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_opnd_d   = alu_opnd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_branch_d = rsp_branch_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          winner_d   = grant1;
          last_d     = grant1;
          alu_ctrl_d = grant1 ? req1_ctrl : req0_ctrl;
          alu_opnd_d = grant1 ? req1_opnd : req0_opnd;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d[winner_q]  = 1'b1;
        rsp_result_d[winner_q] = alu_result;
        rsp_zero_d[winner_q]   = alu_zero;
        rsp_branch_d[winner_q] = alu_branch;
        state_d                = RESP;
      end
      RESP: begin
        if (rsp_taken) begin
          rsp_valid_d[winner_q] = 1'b0;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      winner_q     <= 1'b0;
      alu_ctrl_q   <= '0;
      alu_opnd_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_zero_q   <= '0;
      rsp_branch_q <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      winner_q     <= winner_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_opnd_q   <= alu_opnd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_branch_q <= rsp_branch_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  // Operand bundle is packed {pc, imm32, read_data_2, read_data_1}.
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_rd1     = alu_opnd_q[DATA_W-1:0];
  assign alu_rd2     = alu_opnd_q[2*DATA_W-1:DATA_W];
  assign alu_imm     = alu_opnd_q[3*DATA_W-1:2*DATA_W];
  assign alu_pc      = alu_opnd_q[4*DATA_W-1:3*DATA_W];
  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp0_result = rsp_result_q[0];
  assign rsp0_zero   = rsp_zero_q[0];
  assign rsp0_branch = rsp_branch_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp1_result = rsp_result_q[1];
  assign rsp1_zero   = rsp_zero_q[1];
  assign rsp1_branch = rsp_branch_q[1];
  assign busy        = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Clear wins over a same-cycle grant.
  always_comb begin
    cnt0_d = stats_clr ? 32'd0 : cnt0_q + {31'd0, grant0};
    cnt1_d = stats_clr ? 32'd0 : cnt1_q + {31'd0, grant1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter : directed bench with a transaction-level model of the
// shared-ALU arbiter. Define ALU_ARB_STATS_EN to cover grant counters. Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int CW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [CW-1:0] req0_ctrl = '0, req1_ctrl = '0, alu_ctrl;
  logic [4*DW-1:0] req0_opnd = '0, req1_opnd = '0;
  logic [DW-1:0] rsp0_result, rsp1_result, alu_rd1, alu_rd2, alu_pc, alu_imm, alu_result;
  logic          rsp0_zero, rsp0_branch, rsp1_zero, rsp1_branch, alu_zero, alu_branch, busy;
`ifdef ALU_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [31:0]   grant_cnt0, grant_cnt1;
`endif

  alu_share_arbiter #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_opnd(req0_opnd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_opnd(req1_opnd),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_branch(rsp0_branch),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_branch(rsp1_branch),
    .alu_ctrl(alu_ctrl), .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_branch(alu_branch),
`ifdef ALU_ARB_STATS_EN
    .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .busy(busy)
  );

  // Toy ALU: op 0 add, 1 sub, 4 xor, others 0; ALUSrc picks imm; branch = Branch & zero.
  function automatic logic [DW+1:0] alu_fn(input logic [CW-1:0] c, input logic [4*DW-1:0] o);
    logic [DW-1:0] a, b, r;
    a = o[DW-1:0];
    b = c[7] ? o[3*DW-1:2*DW] : o[2*DW-1:DW];
    case (c[11:8])
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd4:    r = a ^ b;
      default: r = '0;
    endcase
    return {c[5] & (r == '0), (r == '0), r};
  endfunction

  assign {alu_branch, alu_zero, alu_result} = alu_fn(alu_ctrl, {alu_pc, alu_imm, alu_rd2, alu_rd1});

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  // Reference model: one operation lifecycle (idle -> computing -> responding).
  int                 m_phase = 0;
  logic               m_last = 1'b1, m_win = 1'b0;
  logic [CW-1:0]      m_ctrl = '0;
  logic [4*DW-1:0]    m_opnd = '0;
  logic [1:0][DW-1:0] m_res = '0;
  logic [1:0]         m_zero = '0, m_br = '0;
  logic [31:0]        m_cnt0 = 0, m_cnt1 = 0;

  initial begin
    logic e0, e1;
    logic [DW+1:0] r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0; m_last = 1'b1; m_win = 1'b0; m_ctrl = '0; m_opnd = '0;
        m_res = '0; m_zero = '0; m_br = '0; m_cnt0 = 0; m_cnt1 = 0;
      end
      e0 = rst_n && m_phase == 0 && req0_valid && (!req1_valid || m_last);
      e1 = rst_n && m_phase == 0 && req1_valid && (!req0_valid || !m_last);
      chk("m_req0_ready", req0_ready, e0);
      chk("m_req1_ready", req1_ready, e1);
      chk("m_busy", busy, m_phase != 0);
      chk("m_rsp0_valid", rsp0_valid, m_phase == 2 && m_win == 1'b0);
      chk("m_rsp1_valid", rsp1_valid, m_phase == 2 && m_win == 1'b1);
      chk("m_rsp0_result", rsp0_result, m_res[0]);
      chk("m_rsp1_result", rsp1_result, m_res[1]);
      chk("m_rsp_flags", {rsp1_branch, rsp1_zero, rsp0_branch, rsp0_zero},
          {m_br[1], m_zero[1], m_br[0], m_zero[0]});
      chk("m_alu_ctrl", alu_ctrl, m_ctrl);
      chk("m_alu_rd1", alu_rd1, m_opnd[DW-1:0]);
      chk("m_alu_rd2", alu_rd2, m_opnd[2*DW-1:DW]);
      chk("m_alu_imm", alu_imm, m_opnd[3*DW-1:2*DW]);
      chk("m_alu_pc", alu_pc, m_opnd[4*DW-1:3*DW]);
`ifdef ALU_ARB_STATS_EN
      chk("m_grant_cnt0", grant_cnt0, m_cnt0);
      chk("m_grant_cnt1", grant_cnt1, m_cnt1);
`endif
      if (rst_n) begin
        case (m_phase)
          0: if (e0 || e1) begin
               m_win = e1; m_last = e1;
               m_ctrl = e1 ? req1_ctrl : req0_ctrl;
               m_opnd = e1 ? req1_opnd : req0_opnd;
               m_phase = 1;
             end
          1: begin
               r = alu_fn(m_ctrl, m_opnd);
               m_res[m_win] = r[DW-1:0]; m_zero[m_win] = r[DW]; m_br[m_win] = r[DW+1];
               m_phase = 2;
             end
          default: if (m_win ? rsp1_ready : rsp0_ready) m_phase = 0;
        endcase
`ifdef ALU_ARB_STATS_EN
        if (stats_clr) begin m_cnt0 = 0; m_cnt1 = 0; end
        else begin m_cnt0 = m_cnt0 + 32'(e0); m_cnt1 = m_cnt1 + 32'(e1); end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 0;
`endif
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic wait_ready(input int ch);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ch == 1 ? req1_ready : req0_ready) return;
    end
    timeout("wait_ready");
  endtask

  task automatic wait_rsp(input int ch, output int lat);
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (ch == 1 ? rsp1_valid : rsp0_valid) return;
    end
    timeout("wait_rsp");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    timeout("wait_idle");
  endtask

  initial begin
    int lat, nr0, nr1, n0, n1;
    int g[$];
    bit dropped;

    // Reset values
    rst_n = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    do_reset();

    // Single add on requester 0: 5 + 7
    rsp0_ready = 1; req0_ctrl = 12'h000; req0_opnd = {32'd0, 32'd0, 32'd7, 32'd5}; req0_valid = 1;
    wait_ready(0);
    chk("t1_req1_ready", req1_ready, 0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("t1_ready_pulse", req0_ready, 0);
      if (rsp0_valid) begin lat = i; break; end
    end
    chk("t1_latency", lat, 2);
    chk("t1_result", rsp0_result, 32'd12);
    chk("t1_zero_branch", {rsp0_zero, rsp0_branch}, 2'b00);
    tick(); req0_valid = 0;
    @(negedge clk);
    chk("t1_busy_done", busy, 0);

    // Both valid: sub 9-9 on req0, xori 0xF0^0x0F on req1
    do_reset();
    req0_ctrl = 12'h100; req0_opnd = {32'd0, 32'd0, 32'd9, 32'd9};
    req1_ctrl = 12'h480; req1_opnd = {32'd0, 32'h0F, 32'd0, 32'hF0};
    rsp0_ready = 1; rsp1_ready = 1; req0_valid = 1; req1_valid = 1;
    nr0 = 0; nr1 = 0; dropped = 0; g.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      if (rsp0_valid) begin
        nr0++;
        chk("t2_rsp0_result", rsp0_result, 0);
        chk("t2_rsp0_zero", rsp0_zero, 1);
      end
      if (rsp1_valid) begin
        nr1++;
        chk("t2_rsp1_result", rsp1_result, 32'hFF);
      end
      if (nr0 + nr1 == 4) break;
      if (g.size() >= 4 && !dropped) begin
        tick(); req0_valid = 0; req1_valid = 0; dropped = 1;
      end
    end
    chk("t2_grant_count", g.size(), 4);
    for (int i = 0; i < g.size() && i < 4; i++) chk("t2_grant_order", g[i], i % 2);
    chk("t2_rsp_counts", {nr0[15:0], nr1[15:0]}, {16'd2, 16'd2});
    wait_idle();

    // Backpressure: beq 3,3 on requester 1 with rsp1_ready low
    do_reset();
    req1_ctrl = 12'h120; req1_opnd = {32'd0, 32'd0, 32'd3, 32'd3}; req1_valid = 1;
    wait_ready(1);
    tick(); req1_valid = 0;
    req0_ctrl = 12'h000; req0_opnd = {32'd0, 32'd0, 32'd2, 32'd1}; req0_valid = 1;
    wait_rsp(1, lat);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_rsp1_valid", rsp1_valid, 1);
      chk("t3_rsp1_branch", rsp1_branch, 1);
      chk("t3_rsp1_result", rsp1_result, 0);
      chk("t3_req0_blocked", req0_ready, 0);
    end
    tick(); rsp1_ready = 1;
    @(negedge clk);
    chk("t3_req0_blocked_last", req0_ready, 0);
    @(negedge clk);
    chk("t3_req0_granted", req0_ready, 1);
    tick(); rsp1_ready = 0; req0_valid = 0; rsp0_ready = 1;
    wait_idle();

    // Reset in the middle of EXEC
    do_reset();
    req0_ctrl = 12'h080; req0_opnd = {32'h44, 32'd7, 32'd7, 32'd5}; req0_valid = 1;
    wait_ready(0);
    tick();
    rst_n = 0; req0_valid = 0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_alu_ctrl", alu_ctrl, 0);
    chk("t4_alu_rd1", alu_rd1, 0);
    chk("t4_alu_pc", alu_pc, 0);
    chk("t4_rsp0_valid", rsp0_valid, 0);
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    end
    tick(); req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("t4_tie_to_req0", {req1_ready, req0_ready}, 2'b01);
    tick(); req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    wait_idle();

    // req1_valid pulses only during requester 0's RESP
    do_reset();
    req0_ctrl = 12'h000; req0_opnd = {32'd0, 32'd0, 32'd1, 32'd1}; req0_valid = 1;
    wait_ready(0);
    tick(); req0_valid = 0;
    wait_rsp(0, lat);
    tick(); req1_valid = 1;
    @(negedge clk);
    chk("t5_req1_not_ready_a", req1_ready, 0);
    tick();
    @(negedge clk);
    chk("t5_req1_not_ready_b", req1_ready, 0);
    tick(); req1_valid = 0; rsp0_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_req1_never", {rsp1_valid, req1_ready}, 2'b00);
    end
    chk("t5_busy", busy, 0);

`ifdef ALU_ARB_STATS_EN
    // Grant counters: 3 grants to req0, 2 to req1, then clear on an accept cycle
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1; req0_valid = 1; req1_valid = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      if (n0 + n1 == 5) break;
    end
    tick(); req0_valid = 0; req1_valid = 0;
    wait_idle();
    chk("t6_cnt0", grant_cnt0, 3);
    chk("t6_cnt1", grant_cnt1, 2);
    tick(); req0_valid = 1; stats_clr = 1;
    @(negedge clk);
    chk("t6_accept_with_clr", req0_ready, 1);
    tick(); req0_valid = 0; stats_clr = 0;
    @(negedge clk);
    chk("t6_clr_cnt0", grant_cnt0, 0);
    chk("t6_clr_cnt1", grant_cnt1, 0);
    wait_idle();
`else
    n0 = 0; n1 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
